fg_detect_stream: RTL and testbench
===================================

# fg_detect_stream

Pipelined, handshaked successor to the single-pixel foreground comparator. Takes a stream of current/background pixel pairs with a parametrised channel count and width, computes per-channel absolute differences, and reduces them to a foreground flag under a run-time selectable mode. It keeps a saturating foreground-pixel counter and can optionally emit a running-average updated background pixel. It sits between the frame-buffer reader and the mask writer in the accelerator datapath.

## Interface
- CHANNELS, 3, colour channels per pixel (≥1)
- WIDTH, 8, bits per channel
- THRESHOLD, 25, reset value of the threshold register
- ALPHA_SHIFT, 3, background learning rate 2^-ALPHA_SHIFT (only used with BG_UPDATE_EN)
- CNT_W, 24, foreground counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input pixel pair valid
- in_ready  out  1  block accepts input this cycle
- in_current  in  CHANNELS*WIDTH  current pixel, channel k at [k*WIDTH +: WIDTH]
- in_background  in  CHANNELS*WIDTH  background pixel, same packing
- cfg_wr  in  1  load cfg_threshold/cfg_mode
- cfg_threshold  in  WIDTH  new threshold
- cfg_mode  in  2  00 ANY, 01 ALL, 10 SUM, 11 reserved (behaves as ANY)
- cnt_clear  in  1  synchronous clear of fg_count
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_foreground  out  1  foreground flag
- out_background  out  CHANNELS*WIDTH  updated (or passed-through) background pixel
- fg_count  out  CNT_W  saturating count of foreground results delivered

## Operation
- Stage 1 (S1): per channel, diff_k = |cur_k − bg_k| (WIDTH bits, exact). Also registers cur, bg.
- Stage 2 (S2): reduce using the threshold register thr and the mode register:
  - ANY: fg = OR over k of (diff_k ≥ thr).
  - ALL: fg = AND over k of (diff_k ≥ thr).
  - SUM: fg = (Σ diff_k ≥ thr × CHANNELS). Sum and product are computed at WIDTH+clog2(CHANNELS)+1 bits, with no overflow.
- Comparison is ≥ in all modes. thr = 0 makes every pixel foreground.
- Config: on cfg_wr, thr and mode load at the next edge. They apply to whichever pixel occupies S2 from that edge onward. There is no per-pixel config tagging.
- Counter: increments on each output handshake (out_valid & out_ready) with out_foreground = 1. It saturates at 2^CNT_W−1. cnt_clear takes priority over a same-cycle increment, and the result is 0.
- Handshake: valid/ready on both sides.
  - Data is held stable while valid and not ready.
  - S2 advances when !S2.valid || out_ready.
  - S1 advances when !S1.valid || S2 advances.
  - in_ready = S1 advance condition. This is combinational from out_ready, with no input-to-output combinational data path.
- Bubbles collapse. Full throughput is one pixel per cycle with out_ready held high.

## Timing
- Latency: 2 cycles from input handshake to out_valid.
- Reset (async assert, sync-safe deassert expected):
  - S1/S2 valid = 0, so out_valid = 0.
  - out_foreground = 0, out_background = 0.
  - fg_count = 0, thr = THRESHOLD, mode = ANY.
  - in_ready = 1 after reset.
- Reset mid-stream: all in-flight pixels are dropped. No partial output.
- Back-pressure: with out_ready low and both stages full, in_ready = 0. The next cycle with out_ready high accepts a new input in that same cycle.

## Configuration
- BG_UPDATE_EN defined:
  - For background pixels (fg = 0), each channel is out_bg_k = bg_k + ((cur_k − bg_k) >>> ALPHA_SHIFT). The difference is signed WIDTH+1 bits with an arithmetic (floor) shift, so the result always stays in [0, 2^WIDTH−1].
  - Foreground pixels pass bg unchanged.
  - The computation is in S2, with no extra latency.
- BG_UPDATE_EN undefined: out_background = registered in_background, unchanged. ALPHA_SHIFT is ignored.

## Test plan
- Reset, ANY mode, CHANNELS=3, thr=25: cur (100,50,50), bg (76,50,50) gives fg=0. bg (75,50,50) gives fg=1 exactly 2 cycles after accept. fg_count=1.
- ALL vs SUM: cfg_wr with mode=01. diffs (30,30,10) give fg=0. With mode=10, sum 70 < 75 gives fg=0, and diffs (30,30,15) with sum 75 give fg=1.
- Back-pressure: stream 8 pixels with out_ready toggling 1,0,0,1. Outputs must arrive in order with none lost or duplicated. in_ready=0 only while both stages are full and out_ready=0.
- Counter edges: preload by streaming foreground pixels with CNT_W=4. After 15 it holds 15. cnt_clear asserted together with a foreground handshake gives 0.
- BG_UPDATE_EN, ALPHA_SHIFT=3, thr=255:
  - cur 100, bg 50 gives out_bg 56.
  - cur 50, bg 100 gives out_bg 93.
  - thr=25 with a foreground pixel gives out_bg = bg.
- Async reset asserted with 2 pixels in flight: out_valid drops immediately, no stale output after release, and thr returns to 25.

Source files
------------

// File: rtl/fg_detect_stream.sv
// Two-stage valid/ready foreground detector: per-channel |cur-bg|, then ANY/ALL/SUM threshold reduction.
// Optional running-average background output when BG_UPDATE_EN is defined.
module fg_detect_stream #(
    parameter int CHANNELS    = 3,
    parameter int WIDTH       = 8,
    parameter int THRESHOLD   = 25,
    parameter int ALPHA_SHIFT = 3,
    parameter int CNT_W       = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_current,
    input  logic [CHANNELS*WIDTH-1:0] in_background,
    input  logic                      cfg_wr,
    input  logic [WIDTH-1:0]          cfg_threshold,
    input  logic [1:0]                cfg_mode,
    input  logic                      cnt_clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_foreground,
    output logic [CHANNELS*WIDTH-1:0] out_background,
    output logic [CNT_W-1:0]          fg_count
);

    localparam int DW = CHANNELS * WIDTH;
    localparam int SW = WIDTH + $clog2(CHANNELS) + 1;

    typedef enum logic [1:0] {
        MODE_ANY  = 2'b00,
        MODE_ALL  = 2'b01,
        MODE_SUM  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    if (CHANNELS < 1 || ALPHA_SHIFT < 0) begin : g_bad_param
        $error("fg_detect_stream: CHANNELS must be >= 1 and ALPHA_SHIFT >= 0");
    end

    logic              s1_valid;
    logic [DW-1:0]     s1_diff;
    logic [DW-1:0]     s1_bg;
`ifdef BG_UPDATE_EN
    logic [DW-1:0]     s1_cur;
`endif
    logic [WIDTH-1:0]  thr;
    mode_t             mode;

    logic              s1_adv;
    logic              s2_adv;
    logic [DW-1:0]     diff_in;
    logic              any_hit;
    logic              all_hit;
    logic [SW-1:0]     diff_sum;
    logic [SW-1:0]     thr_scaled;
    logic              fg_next;
    logic [DW-1:0]     bg_next;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        diff_in = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (in_current[k*WIDTH +: WIDTH] >= in_background[k*WIDTH +: WIDTH])
                diff_in[k*WIDTH +: WIDTH] = in_current[k*WIDTH +: WIDTH] - in_background[k*WIDTH +: WIDTH];
            else
                diff_in[k*WIDTH +: WIDTH] = in_background[k*WIDTH +: WIDTH] - in_current[k*WIDTH +: WIDTH];
        end
    end

    // SW bits hold CHANNELS*(2^WIDTH-1) without overflow for both sum and scaled threshold
    always_comb begin
        any_hit    = 1'b0;
        all_hit    = 1'b1;
        diff_sum   = '0;
        thr_scaled = SW'(thr) * SW'(CHANNELS);
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            any_hit  = any_hit | (s1_diff[k*WIDTH +: WIDTH] >= thr);
            all_hit  = all_hit & (s1_diff[k*WIDTH +: WIDTH] >= thr);
            diff_sum = diff_sum + SW'(s1_diff[k*WIDTH +: WIDTH]);
        end
        case (mode)
            MODE_ALL: fg_next = all_hit;
            MODE_SUM: fg_next = (diff_sum >= thr_scaled);
            default:  fg_next = any_hit;
        endcase
    end

`ifdef BG_UPDATE_EN
    // Signed WIDTH+1 difference with arithmetic shift floors toward -inf, keeping the result in range
    always_comb begin
        bg_next = s1_bg;
        if (!fg_next) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                bg_next[k*WIDTH +: WIDTH] = WIDTH'($signed({1'b0, s1_bg[k*WIDTH +: WIDTH]})
                    + (($signed({1'b0, s1_cur[k*WIDTH +: WIDTH]})
                        - $signed({1'b0, s1_bg[k*WIDTH +: WIDTH]})) >>> ALPHA_SHIFT));
            end
        end
    end
`else
    assign bg_next = s1_bg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_bg    <= '0;
`ifdef BG_UPDATE_EN
            s1_cur   <= '0;
`endif
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_diff <= diff_in;
                s1_bg   <= in_background;
`ifdef BG_UPDATE_EN
                s1_cur  <= in_current;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_foreground <= 1'b0;
            out_background <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_foreground <= fg_next;
                out_background <= bg_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr  <= WIDTH'(THRESHOLD);
            mode <= MODE_ANY;
        end else if (cfg_wr) begin
            thr  <= cfg_threshold;
            mode <= mode_t'(cfg_mode);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fg_count <= '0;
        end else if (cnt_clear) begin
            fg_count <= '0;
        end else if (out_valid && out_ready && out_foreground && (fg_count != '1)) begin
            fg_count <= fg_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fg_detect_stream.sv
// Bench for fg_detect_stream (3 channels x 8 bits, 4-bit counter); follows BG_UPDATE_EN when defined.
module tb_fg_detect_stream;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int DW = CH * W;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_current;
    logic [DW-1:0] in_background;
    logic          cfg_wr;
    logic [W-1:0]  cfg_threshold;
    logic [1:0]    cfg_mode;
    logic          cnt_clear;
    logic          out_valid;
    logic          out_ready;
    logic          out_foreground;
    logic [DW-1:0] out_background;
    logic [3:0]    fg_count;

    fg_detect_stream #(
        .CHANNELS(3), .WIDTH(8), .THRESHOLD(25), .ALPHA_SHIFT(3), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_current(in_current), .in_background(in_background),
        .cfg_wr(cfg_wr), .cfg_threshold(cfg_threshold), .cfg_mode(cfg_mode),
        .cnt_clear(cnt_clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_foreground(out_foreground), .out_background(out_background),
        .fg_count(fg_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fg;
        logic [DW-1:0] bg;
    } exp_t;

    exp_t       q[$];
    int         thr_m;
    logic [1:0] mode_m;
    int         cnt_m;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [DW-1:0] c, input logic [DW-1:0] b,
                                   input int thr, input logic [1:0] mode);
        exp_t r;
        int sum = 0;
        bit any = 1'b0;
        bit all = 1'b1;
        r.bg = b;
        for (int k = 0; k < CH; k++) begin
            int a = int'(c[k*W +: W]);
            int g = int'(b[k*W +: W]);
            int d = (a > g) ? a - g : g - a;
            any = any | (d >= thr);
            all = all & (d >= thr);
            sum += d;
        end
        case (mode)
            2'd1:    r.fg = all;
            2'd2:    r.fg = (sum >= thr * CH);
            default: r.fg = any;
        endcase
`ifdef BG_UPDATE_EN
        if (!r.fg) begin
            for (int k = 0; k < CH; k++) begin
                int a  = int'(c[k*W +: W]);
                int g  = int'(b[k*W +: W]);
                int df = a - g;
                int st = (df >= 0) ? df / 8 : -((-df + 7) / 8);
                r.bg[k*W +: W] = 8'(g + st);
            end
        end
`endif
        return r;
    endfunction

    function automatic void rand_px(output logic [DW-1:0] c, output logic [DW-1:0] b);
        for (int k = 0; k < CH; k++) begin
            int bb = int'($urandom_range(0, 255));
            int cc;
            if ($urandom_range(0, 1) == 1) begin
                cc = int'($urandom_range(0, 255));
            end else begin
                int d = int'($urandom_range(0, 40));
                cc = ($urandom_range(0, 1) == 1) ? bb + d : bb - d;
                if (cc < 0) cc = 0;
                if (cc > 255) cc = 255;
            end
            c[k*W +: W] = 8'(cc);
            b[k*W +: W] = 8'(bb);
        end
    endfunction

    // Output scoreboard, occupancy-based in_ready check and counter model
    always @(negedge clk) begin : mon
        exp_t e;
        bit   hs_fg;
        if (rst_n) begin
            hs_fg = 1'b0;
            chk("fg_count", fg_count, cnt_m);
            chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
            if (q.size() == 0) begin
                chk("spurious_out_valid", out_valid, 1'b0);
            end else if (out_valid && out_ready) begin
                e = q.pop_front();
                chk("out_foreground", out_foreground, e.fg);
                chk("out_background", out_background, e.bg);
                hs_fg = e.fg;
            end
            if (cnt_clear) cnt_m = 0;
            else if (hs_fg && cnt_m < CNT_MAX) cnt_m++;
            if (in_valid && in_ready) q.push_back(model(in_current, in_background, thr_m, mode_m));
            if (cfg_wr) begin
                thr_m  = int'(cfg_threshold);
                mode_m = cfg_mode;
            end
        end
    end

    task automatic cfg(input int thr, input logic [1:0] mode);
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_threshold = 8'(thr); cfg_mode = mode;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    task automatic run_pixel(input logic [DW-1:0] c, input logic [DW-1:0] b,
                             output logic fg, output logic [DW-1:0] ob, output int lat);
        int g = 0;
        @(posedge clk); #1;
        in_current = c; in_background = b; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        fg = out_foreground;
        ob = out_background;
    endtask

    task automatic drain();
        int g = 0;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
        while (q.size() != 0 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    // rmode: 0 random ready + occasional clear, 1 ready pattern 1,0,0,1, 2 ready held high
    task automatic stream(input int n, input int rmode);
        int sent = 0;
        int cyc = 0;
        bit acc;
        logic [DW-1:0] c, b;
        while (sent < n && cyc < 4000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) sent++;
            if (!in_valid || acc) begin
                if (sent < n && $urandom_range(0, 3) != 0) begin
                    rand_px(c, b);
                    in_current = c; in_background = b; in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            case (rmode)
                0: begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    cnt_clear = ($urandom_range(0, 39) == 0);
                end
                1: begin
                    out_ready = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                    cnt_clear = 1'b0;
                end
                default: begin
                    out_ready = 1'b1;
                    cnt_clear = 1'b0;
                end
            endcase
        end
        chk("stream_accepted", sent, n);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic          fg;
        logic [DW-1:0] ob;
        logic [DW-1:0] exp_bg;
        int            lat;

        rst_n = 1'b0; in_valid = 1'b0; in_current = '0; in_background = '0;
        cfg_wr = 1'b0; cfg_threshold = '0; cfg_mode = '0; cnt_clear = 1'b0; out_ready = 1'b1;
        thr_m = 25; mode_m = 2'd0; cnt_m = 0;

        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_foreground", out_foreground, 1'b0);
        chk("rst_out_background", out_background, 24'h0);
        chk("rst_fg_count", fg_count, 4'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1'b1);

        // ANY mode threshold boundary, channel 0 carries the difference
        run_pixel({8'd50, 8'd50, 8'd100}, {8'd50, 8'd50, 8'd76}, fg, ob, lat);
        chk("any_diff24_fg", fg, 1'b0);
        chk("any_diff24_latency", lat, 2);
        run_pixel({8'd50, 8'd50, 8'd100}, {8'd50, 8'd50, 8'd75}, fg, ob, lat);
        chk("any_diff25_fg", fg, 1'b1);
        chk("any_diff25_latency", lat, 2);
        @(posedge clk); @(negedge clk);
        chk("count_after_first_fg", fg_count, 4'd1);

        cfg(25, 2'd1);
        run_pixel({8'd60, 8'd80, 8'd80}, {8'd50, 8'd50, 8'd50}, fg, ob, lat);
        chk("all_30_30_10_fg", fg, 1'b0);
        cfg(25, 2'd2);
        run_pixel({8'd60, 8'd80, 8'd80}, {8'd50, 8'd50, 8'd50}, fg, ob, lat);
        chk("sum_70_fg", fg, 1'b0);
        run_pixel({8'd65, 8'd80, 8'd80}, {8'd50, 8'd50, 8'd50}, fg, ob, lat);
        chk("sum_75_fg", fg, 1'b1);
        cfg(25, 2'd3);
        run_pixel({8'd50, 8'd50, 8'd75}, {8'd50, 8'd50, 8'd50}, fg, ob, lat);
        chk("reserved_as_any_fg", fg, 1'b1);

        cfg(255, 2'd0);
`ifdef BG_UPDATE_EN
        exp_bg = {3{8'd56}};
`else
        exp_bg = {3{8'd50}};
`endif
        run_pixel({3{8'd100}}, {3{8'd50}}, fg, ob, lat);
        chk("bg_up_rise", ob, exp_bg);
`ifdef BG_UPDATE_EN
        exp_bg = {3{8'd93}};
`else
        exp_bg = {3{8'd100}};
`endif
        run_pixel({3{8'd50}}, {3{8'd100}}, fg, ob, lat);
        chk("bg_up_fall", ob, exp_bg);
        cfg(25, 2'd0);
        run_pixel({3{8'd100}}, {3{8'd50}}, fg, ob, lat);
        chk("bg_fg_fg", fg, 1'b1);
        chk("bg_fg_passthrough", ob, {3{8'd50}});

        cfg(40, 2'd2);
        stream(8, 1);
        cfg(20, 2'd0);
        stream(32, 1);

        for (int i = 0; i < 8; i++) begin
            int t = int'($urandom_range(0, 60));
            if (i == 2) t = 0;
            if (i == 5) t = 255;
            cfg(t, 2'($urandom_range(0, 3)));
            stream(40, 0);
        end

        // Counter saturation then clear racing a foreground handshake
        @(posedge clk); #1 cnt_clear = 1'b1;
        @(posedge clk); #1 cnt_clear = 1'b0;
        cfg(0, 2'd0);
        stream(20, 2);
        @(negedge clk);
        chk("count_saturated", fg_count, 4'd15);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        in_current = {3{8'd9}}; in_background = {3{8'd1}};
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1; cnt_clear = 1'b1;
        @(negedge clk);
        chk("clear_race_out_valid", out_valid, 1'b1);
        chk("clear_race_pre_count", fg_count, 4'd15);
        @(posedge clk); #1 cnt_clear = 1'b0;
        @(negedge clk);
        chk("clear_race_count", fg_count, 4'd0);
        drain();

        // Reset with both stages full under back-pressure
        cfg(255, 2'd1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        in_current = {3{8'd200}}; in_background = {3{8'd0}};
        @(posedge clk); #1;
        in_current = {3{8'd0}}; in_background = {3{8'd200}};
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_out_valid", out_valid, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        q.delete(); thr_m = 25; mode_m = 2'd0; cnt_m = 0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); @(posedge clk); #3;
        out_ready = 1'b1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        run_pixel({8'd50, 8'd75, 8'd50}, {8'd50, 8'd50, 8'd50}, fg, ob, lat);
        chk("thr_reset_diff25_fg", fg, 1'b1);
        run_pixel({8'd74, 8'd50, 8'd50}, {8'd50, 8'd50, 8'd50}, fg, ob, lat);
        chk("thr_reset_diff24_fg", fg, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
